debug_controller: RTL and testbench
===================================

DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 Parameter RUN_LIMIT, default 32'hFFFF_FFFF; maximum cpu_step pulses in one RUN before forced halt.
REQ-002 Parameter TX_LSB_FIRST, default 1; byte order of multi-byte replies (1 = bits 7:0 first).
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  command byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_data  output  8  reply byte to transmitter.
REQ-009 tx_start  output  1  one-cycle strobe launching tx_data.
REQ-010 code  output  8  probe select driven to the pipeline debug decoder.
REQ-011 result  input  32  probe value returned for code.
REQ-012 size  input  2  probe width: 2'b11 = 4 bytes, any other value = 1 byte.
REQ-013 cpu_step  output  1  one-cycle pipeline clock-enable pulse.
REQ-014 halt_in  input  1  pipeline end-of-program indication.
REQ-015 running  output  1  high while in RUN.
REQ-016 cmd_drop  output  1  one-cycle pulse when a command byte is discarded.

Function
REQ-017 States SHALL be IDLE, PROBE, LATCH, SEND, WAIT_TX, STEP, RUN.
REQ-018 IDLE + rx_valid with rx_data in 8'h01..8'h5F: code <= rx_data, go to PROBE.
REQ-019 PROBE lasts exactly one cycle (decoder settle); LATCH captures result and size into shadow registers, loads byte count 4 (size==2'b11) or 1, and goes to SEND.
REQ-020 SEND: when tx_busy==0, drive the next byte on tx_data, pulse tx_start one cycle, decrement count, go to WAIT_TX.
REQ-021 WAIT_TX: ignore tx_busy for the first cycle; thereafter return to SEND when tx_busy==0 and count>0, otherwise to IDLE when tx_busy==0 and count==0.
REQ-022 A 1-byte reply SHALL send result[7:0]; 4-byte replies follow TX_LSB_FIRST.
REQ-023 IDLE + rx_valid with 8'h3F (STEP): go to STEP, pulse cpu_step exactly once, increment step_cnt, send 1-byte ack 8'hFF, then return to IDLE.
REQ-024 IDLE + 8'h60 (RUN): enter RUN, running=1, pulse cpu_step every cycle, step_cnt incremented per pulse.
REQ-025 RUN exits on the first of: halt_in==1 (sampled before the pulse; no pulse that cycle), rx 8'h61 (STOP), or RUN_LIMIT pulses in this run; on exit running=0 and ack 8'hA5 (halt/limit) or 8'h5A (STOP) is sent.
REQ-026 IDLE + 8'h62: send 32-bit step_cnt as 4 bytes via SEND/WAIT_TX; IDLE + 8'h63: clear step_cnt, ack 8'hFF.
REQ-027 step_cnt SHALL be 32-bit and wrap from 32'hFFFF_FFFF to 0 without flag.
REQ-028 Bytes 8'h00 and 8'h64..8'hFF in IDLE: discarded, cmd_drop pulses once, no reply.
REQ-029 rx_valid in any state other than IDLE (excluding STOP during RUN): byte discarded, cmd_drop pulses, current operation unaffected.
REQ-030 STOP and halt_in in the same RUN cycle: halt takes priority, ack 8'hA5.
REQ-031 code SHALL hold its value outside PROBE/LATCH/SEND/WAIT_TX and be 8'h00 in RUN and STEP.
REQ-032 Shadow result SHALL not change during SEND/WAIT_TX even if the result input changes.

Reset
REQ-033 reset low SHALL immediately force IDLE; code=8'h00, tx_data=8'h00, tx_start=0, cpu_step=0, running=0, cmd_drop=0, step_cnt=0, shadow registers=0.
REQ-034 Reset asserted mid-reply or mid-RUN SHALL abort with no further tx_start or cpu_step pulses; no partial-reply resumption after release.
REQ-035 The first command SHALL be accepted in the first cycle after reset release.

Verification
REQ-036 rx 8'h01, result=32'h1234_5678, size=2'b11 -> code=8'h01 and tx bytes 8'h78,8'h56,8'h34,8'h12 in order, one tx_start each, each after tx_busy drops.
REQ-037 rx 8'h02, result=32'h0000_0007, size=2'b00 -> single byte 8'h07, then IDLE.
REQ-038 rx 8'h3F x3, then 8'h62 -> three single cpu_step pulses, three 8'hFF acks, then bytes 8'h03,8'h00,8'h00,8'h00.
REQ-039 rx 8'h60, halt_in raised after 10 pulses -> exactly 10 cpu_step pulses, running falls, ack 8'hA5; with RUN_LIMIT=5 and no halt -> 5 pulses, ack 8'hA5.
REQ-040 rx 8'h60, then 8'h61 -> pulses stop the cycle after STOP, ack 8'h5A; rx 8'h01 during a reply -> cmd_drop pulse, reply bytes unchanged.
REQ-041 reset low during the 2nd byte of a 4-byte reply -> all outputs at reset values immediately, no further tx_start pulses after release.

Source files
------------

// File: rtl/debug_controller.sv
// debug_controller: byte-command debug monitor that sits between a UART and a
// pipelined CPU. It reads probe values through the debug decoder, single-steps
// or free-runs the pipeline, and reports step counts and acknowledgements.
module debug_controller #(
  parameter logic [31:0] RUN_LIMIT    = 32'hFFFF_FFFF,
  parameter bit          TX_LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [7:0]  code,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic        cpu_step,
  input  logic        halt_in,
  output logic        running,
  output logic        cmd_drop
);

  localparam logic [7:0] CMD_STEP  = 8'h3F;
  localparam logic [7:0] CMD_RUN   = 8'h60;
  localparam logic [7:0] CMD_STOP  = 8'h61;
  localparam logic [7:0] CMD_READ  = 8'h62;
  localparam logic [7:0] CMD_CLEAR = 8'h63;
  localparam logic [7:0] ACK_OK    = 8'hFF;
  localparam logic [7:0] ACK_HALT  = 8'hA5;
  localparam logic [7:0] ACK_STOP  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE, PROBE, LATCH, SEND, WAIT_TX, STEP, RUN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] shadow, shadow_nxt;
  logic [2:0]  count, count_nxt;
  logic        len4, len4_nxt;
  logic        wait_first, wait_first_nxt;
  logic [7:0]  code_nxt;
  logic [31:0] step_cnt, step_cnt_nxt;
  logic [31:0] run_cnt, run_cnt_nxt;
  logic [1:0]  byte_idx;
  logic [7:0]  send_byte;

  // Pick the reply byte for the current position; single-byte replies are always bits 7:0
  always_comb begin
    byte_idx = 2'(3'd4 - count);
    if (!len4) begin
      send_byte = shadow[7:0];
    end else if (TX_LSB_FIRST) begin
      send_byte = shadow[8*byte_idx +: 8];
    end else begin
      send_byte = shadow[8*(~byte_idx) +: 8];
    end
  end

  // Next-state, datapath updates and pulse outputs for the command FSM
  always_comb begin
    state_nxt      = state;
    shadow_nxt     = shadow;
    count_nxt      = count;
    len4_nxt       = len4;
    wait_first_nxt = wait_first;
    code_nxt       = code;
    step_cnt_nxt   = step_cnt;
    run_cnt_nxt    = run_cnt;
    tx_data        = 8'h00;
    tx_start       = 1'b0;
    cpu_step       = 1'b0;
    cmd_drop       = 1'b0;
    running        = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_STEP) begin
            code_nxt  = 8'h00;
            state_nxt = STEP;
          end else if (rx_data >= 8'h01 && rx_data <= 8'h5F) begin
            code_nxt  = rx_data;
            state_nxt = PROBE;
          end else if (rx_data == CMD_RUN) begin
            code_nxt    = 8'h00;
            run_cnt_nxt = 32'd0;
            state_nxt   = RUN;
          end else if (rx_data == CMD_READ) begin
            shadow_nxt = step_cnt;
            len4_nxt   = 1'b1;
            count_nxt  = 3'd4;
            state_nxt  = SEND;
          end else if (rx_data == CMD_CLEAR) begin
            step_cnt_nxt = 32'd0;
            shadow_nxt   = {24'h0, ACK_OK};
            len4_nxt     = 1'b0;
            count_nxt    = 3'd1;
            state_nxt    = SEND;
          end else begin
            cmd_drop = 1'b1;
          end
        end
      end
      PROBE: begin
        cmd_drop  = rx_valid;
        state_nxt = LATCH;
      end
      LATCH: begin
        cmd_drop   = rx_valid;
        shadow_nxt = result;
        len4_nxt   = (size == 2'b11);
        count_nxt  = (size == 2'b11) ? 3'd4 : 3'd1;
        state_nxt  = SEND;
      end
      SEND: begin
        cmd_drop = rx_valid;
        if (!tx_busy) begin
          tx_data        = send_byte;
          tx_start       = 1'b1;
          count_nxt      = count - 3'd1;
          wait_first_nxt = 1'b1;
          state_nxt      = WAIT_TX;
        end
      end
      WAIT_TX: begin
        cmd_drop = rx_valid;
        if (wait_first) begin
          wait_first_nxt = 1'b0;
        end else if (!tx_busy) begin
          state_nxt = (count != 3'd0) ? SEND : IDLE;
        end
      end
      STEP: begin
        cmd_drop     = rx_valid;
        cpu_step     = 1'b1;
        step_cnt_nxt = step_cnt + 32'd1;
        shadow_nxt   = {24'h0, ACK_OK};
        len4_nxt     = 1'b0;
        count_nxt    = 3'd1;
        state_nxt    = SEND;
      end
      RUN: begin
        running  = 1'b1;
        cmd_drop = rx_valid && (rx_data != CMD_STOP);
        len4_nxt  = 1'b0;
        count_nxt = 3'd1;
        if (halt_in) begin
          shadow_nxt = {24'h0, ACK_HALT};
          state_nxt  = SEND;
        end else if (rx_valid && rx_data == CMD_STOP) begin
          shadow_nxt = {24'h0, ACK_STOP};
          state_nxt  = SEND;
        end else begin
          cpu_step     = 1'b1;
          step_cnt_nxt = step_cnt + 32'd1;
          run_cnt_nxt  = run_cnt + 32'd1;
          if (run_cnt == RUN_LIMIT - 32'd1) begin
            shadow_nxt = {24'h0, ACK_HALT};
            state_nxt  = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any reply or run in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shadow     <= 32'd0;
      count      <= 3'd0;
      len4       <= 1'b0;
      wait_first <= 1'b0;
      code       <= 8'h00;
      step_cnt   <= 32'd0;
      run_cnt    <= 32'd0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      count      <= count_nxt;
      len4       <= len4_nxt;
      wait_first <= wait_first_nxt;
      code       <= code_nxt;
      step_cnt   <= step_cnt_nxt;
      run_cnt    <= run_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: randomized command traffic against a transaction-level
// model of the debug controller (expected reply bytes, pulse counts, drops).
module tb_debug_controller;

  localparam logic [31:0] LIMIT = 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [7:0]  code;
  logic [31:0] result = 32'd0;
  logic [1:0]  size = 2'b00;
  logic        cpu_step;
  logic        halt_in = 1'b0;
  logic        running;
  logic        cmd_drop;

  debug_controller #(.RUN_LIMIT(LIMIT), .TX_LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .code(code),
    .result(result), .size(size), .cpu_step(cpu_step), .halt_in(halt_in),
    .running(running), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  int          checks_total = 0;
  int          checks_passed = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  code_q[$];
  int          step_pulses = 0;
  int          run_pulses = 0;
  int          drop_count = 0;
  int          bad_starts = 0;
  bit          start_seen = 1'b0;
  int          busy_left = 0;
  logic [31:0] step_model = 32'd0;

  // Observe DUT outputs mid-cycle and log every transaction-level event
  always @(negedge clk) begin
    start_seen = tx_start;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      code_q.push_back(code);
      if (tx_busy) bad_starts++;
    end
    if (cpu_step) begin
      step_pulses++;
      if (running) run_pulses++;
    end
    if (cmd_drop) drop_count++;
  end

  // UART transmitter model: busy for a random 1..4 cycles after each start
  always @(posedge clk) begin
    #1;
    if (busy_left > 0) busy_left--;
    if (start_seen) busy_left = $urandom_range(1, 4);
    tx_busy = (busy_left > 0);
  end

  // Hard stop in case the stimulus itself wedges
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, actual, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cycles(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] logged_byte(input int idx);
    return (idx < tx_q.size()) ? tx_q[idx] : 8'hxx;
  endfunction

  function automatic logic [7:0] logged_code(input int idx);
    return (idx < code_q.size()) ? code_q[idx] : 8'hxx;
  endfunction

  // Wait for n reply bytes, optionally disturbing result or injecting a byte mid-reply
  task automatic wait_reply(input string tag, input int n, input int qb, input bit scramble, input bit inject);
    int budget = 300;
    bit injected = 1'b0;
    while (tx_q.size() < qb + n && budget > 0) begin
      if (tx_q.size() > qb) begin
        if (scramble) result = $urandom;
        if (inject && !injected) begin
          rx_valid = 1'b1;
          rx_data  = 8'h01;
          injected = 1'b1;
        end
      end
      cycles(1);
      rx_valid = 1'b0;
      budget--;
    end
    if (budget == 0) check_output({tag, "_timeout"}, 32'(tx_q.size() - qb), 32'(n));
    cycles(12);
    check_output({tag, "_len"}, 32'(tx_q.size() - qb), 32'(n));
  endtask

  // Reply bytes leave least-significant byte first
  task automatic check_reply(input string tag, input int qb, input int n, input logic [31:0] value);
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("%s_byte%0d", tag, i), 32'(logged_byte(qb + i)), 32'(value[8*i +: 8]));
    end
  endtask

  task automatic do_probe(input logic [7:0] c, input logic [31:0] r, input logic [1:0] s, input bit inject);
    int qb = tx_q.size();
    int db = drop_count;
    int n = (s == 2'b11) ? 4 : 1;
    logic [31:0] expv = (s == 2'b11) ? r : {24'h0, r[7:0]};
    result = r;
    size   = s;
    drive_byte(c);
    wait_reply("probe", n, qb, 1'b1, inject && (n == 4));
    check_reply("probe", qb, n, expv);
    check_output("probe_code", 32'(logged_code(qb)), 32'(c));
    check_output("probe_drops", 32'(drop_count - db), (inject && n == 4) ? 32'd1 : 32'd0);
  endtask

  task automatic do_step();
    int qb = tx_q.size();
    int pb = step_pulses;
    drive_byte(8'h3F);
    wait_reply("step", 1, qb, 1'b0, 1'b0);
    check_reply("step_ack", qb, 1, 32'h0000_00FF);
    check_output("step_pulses", 32'(step_pulses - pb), 32'd1);
    check_output("step_code", 32'(logged_code(qb)), 32'd0);
    step_model = step_model + 32'd1;
  endtask

  task automatic do_read();
    int qb = tx_q.size();
    drive_byte(8'h62);
    wait_reply("read", 4, qb, 1'b0, 1'b0);
    check_reply("read", qb, 4, step_model);
  endtask

  task automatic do_clear();
    int qb = tx_q.size();
    drive_byte(8'h63);
    wait_reply("clear", 1, qb, 1'b0, 1'b0);
    check_reply("clear_ack", qb, 1, 32'h0000_00FF);
    step_model = 32'd0;
  endtask

  task automatic do_drop(input logic [7:0] b);
    int qb = tx_q.size();
    int db = drop_count;
    int pb = step_pulses;
    drive_byte(b);
    cycles(10);
    check_output("drop_count", 32'(drop_count - db), 32'd1);
    check_output("drop_noreply", 32'(tx_q.size() - qb), 32'd0);
    check_output("drop_nostep", 32'(step_pulses - pb), 32'd0);
  endtask

  // mode 0: halt after k pulses, 1: STOP after k, 2: run to the limit (stray byte mid-run), 3: halt+STOP together
  task automatic do_run(input int mode, input int k);
    int qb = tx_q.size();
    int pb = step_pulses;
    int rb = run_pulses;
    int db = drop_count;
    int budget = 100;
    int n;
    bit fired = 1'b0;
    int exp_p = (mode == 2) ? int'(LIMIT) : k;
    logic [7:0] ack = (mode == 1) ? 8'h5A : 8'hA5;
    rx_valid = 1'b1;
    rx_data  = 8'h60;
    while (tx_q.size() == qb && budget > 0) begin
      cycles(1);
      rx_valid = 1'b0;
      budget--;
      n = step_pulses - pb;
      if (!fired) begin
        if (mode == 2) begin
          if (n >= 3) begin
            fired    = 1'b1;
            rx_valid = 1'b1;
            rx_data  = 8'h20;
          end
        end else if (n >= k) begin
          fired = 1'b1;
          if (mode == 0 || mode == 3) halt_in = 1'b1;
          if (mode == 1 || mode == 3) begin
            rx_valid = 1'b1;
            rx_data  = 8'h61;
          end
        end
      end
    end
    rx_valid = 1'b0;
    halt_in  = 1'b0;
    if (budget == 0) check_output("run_timeout", 32'(tx_q.size() - qb), 32'd1);
    wait_reply("run", 1, qb, 1'b0, 1'b0);
    check_reply("run_ack", qb, 1, {24'h0, ack});
    check_output("run_pulses", 32'(step_pulses - pb), 32'(exp_p));
    check_output("run_pulses_running", 32'(run_pulses - rb), 32'(exp_p));
    check_output("run_running_low", 32'(running), 32'd0);
    check_output("run_code", 32'(logged_code(qb)), 32'd0);
    check_output("run_drops", 32'(drop_count - db), (mode == 2) ? 32'd1 : 32'd0);
    step_model = step_model + 32'(exp_p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check_output({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check_output({tag, "_cpu_step"}, 32'(cpu_step), 32'd0);
    check_output({tag, "_running"}, 32'(running), 32'd0);
    check_output({tag, "_cmd_drop"}, 32'(cmd_drop), 32'd0);
    check_output({tag, "_code"}, 32'(code), 32'd0);
  endtask

  // Reset during the second byte of a 4-byte reply must cut it short for good
  task automatic do_reset_mid_reply();
    int qb = tx_q.size();
    int budget = 100;
    result = 32'hCAFE_F00D;
    size   = 2'b11;
    drive_byte(8'h05);
    while (tx_q.size() == qb && budget > 0) begin
      cycles(1);
      budget--;
    end
    if (budget == 0) check_output("rst_timeout", 32'(tx_q.size() - qb), 32'd1);
    cycles(1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    cycles(3);
    reset = 1'b1;
    cycles(15);
    check_output("rst_no_resume", 32'(tx_q.size() - qb), 32'd1);
    step_model = 32'd0;
  endtask

  task automatic apply_stimulus();
    int qb;
    int pb;
    logic [7:0] c;
    int sel;
    reset = 1'b0;
    cycles(2);
    check_reset_outputs("por");
    // first command arrives in the very first cycle after release
    qb = tx_q.size();
    pb = step_pulses;
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h3F;
    cycles(1);
    rx_valid = 1'b0;
    wait_reply("first", 1, qb, 1'b0, 1'b0);
    check_reply("first_ack", qb, 1, 32'h0000_00FF);
    check_output("first_pulse", 32'(step_pulses - pb), 32'd1);
    step_model = 32'd1;

    do_probe(8'h01, 32'h1234_5678, 2'b11, 1'b0);
    do_probe(8'h02, 32'h0000_0007, 2'b00, 1'b0);
    do_clear();
    do_step();
    do_step();
    do_step();
    do_read();
    do_run(0, 10);
    do_run(2, 0);
    do_run(1, 4);
    do_run(3, 6);
    do_run(0, 0);
    do_probe(8'h01, 32'h89AB_CDEF, 2'b11, 1'b1);
    do_drop(8'h00);
    do_drop(8'h64);
    do_drop(8'hFF);
    do_read();
    do_reset_mid_reply();
    do_read();

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: begin
          c = 8'($urandom_range(1, 95));
          if (c == 8'h3F) c = 8'h3E;
          do_probe(c, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        1: do_step();
        2: do_run($urandom_range(0, 3), $urandom_range(0, 11));
        3: do_read();
        4: do_clear();
        default: begin
          case ($urandom_range(0, 2))
            0: c = 8'h00;
            1: c = 8'h61;
            default: c = 8'($urandom_range(100, 255));
          endcase
          do_drop(c);
        end
      endcase
    end
    do_read();
  endtask

  initial begin
    apply_stimulus();
    check_output("start_while_busy", 32'(bad_starts), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
